// File: rtl/mission_sequencer_pkg.sv
// Shared encodings for the line-following cart: colour codes and the
// mission state codes, which double as the seven-segment display value.
package mission_sequencer_pkg;

    typedef enum logic [1:0] {
        COL_NONE  = 2'b00,
        COL_RED   = 2'b01,
        COL_GREEN = 2'b10,
        COL_BLUE  = 2'b11
    } color_t;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'h0,
        ST_TRACK = 4'h1,
        ST_CHECK = 4'h2,
        ST_UTURN = 4'h3,
        ST_BUZZ  = 4'h4,
        ST_DONE  = 4'h5,
        ST_FAIL  = 4'hF
    } state_t;

    localparam int unsigned WD_WIDTH  = 26;
    localparam int unsigned CNT_WIDTH = 4;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (value == '1) ? value : value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/hall_debounce.sv
// Hall-sensor conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted 0->1 transition of the filtered level.
module hall_debounce #(
    parameter int unsigned DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic hall,
    output logic rise
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

    logic [1:0]  sync;
    logic [15:0] cnt;
    logic        level;
    logic        level_d;

    // Filtered level moves only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], hall};
            level_d <= level;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/mission_sequencer.sv
// Top-level mission FSM: tracks the line, checks stations on hall markers,
// performs bounded U-turns, buzzes on a colour match; watchdog guards UTURN/BUZZ.
module mission_sequencer
    import mission_sequencer_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 1000,
    parameter int unsigned MAX_LAPS       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hall,
    input  logic [1:0] object_color,
    input  logic [1:0] station_color,
    input  logic       end_of_track,
    input  logic       uturn_finished,
    input  logic       buzz_finished,
    output logic       en_tracking,
    output logic       en_uturn,
    output logic       en_buzz,
    output logic [3:0] ssd_code,
    output logic [3:0] station_cnt
);

    localparam logic [WD_WIDTH-1:0]  WD_LAST   = WD_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LAPS_LAST = CNT_WIDTH'(MAX_LAPS);

    state_t               state, state_nx;
    color_t               color_q, color_nx;
    logic [CNT_WIDTH-1:0] laps, laps_nx;
    logic [CNT_WIDTH-1:0] station_nx;
    logic [WD_WIDTH-1:0]  wd, wd_nx;
    logic                 wd_hit;
    logic                 hall_rise;

    hall_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_hall_debounce (
        .clk (clk),
        .rst (rst),
        .hall(hall),
        .rise(hall_rise)
    );

    always_comb begin
        state_nx   = state;
        color_nx   = color_q;
        laps_nx    = laps;
        station_nx = station_cnt;
        wd_hit     = (wd == WD_LAST);

        case (state)
            ST_IDLE: begin
                if (object_color != COL_NONE) begin
                    color_nx = color_t'(object_color);
                    state_nx = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (hall_rise) begin
                    state_nx = ST_CHECK;
                end else if (end_of_track) begin
                    if (laps == LAPS_LAST) begin
                        state_nx = ST_FAIL;
                    end else begin
                        state_nx = ST_UTURN;
                        laps_nx  = laps + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_CHECK: begin
                if (station_color == color_q) begin
                    state_nx = ST_BUZZ;
                end else begin
                    station_nx = sat_inc(station_cnt);
                    state_nx   = ST_TRACK;
                end
            end
            // A finished pulse in the timeout cycle still wins.
            ST_UTURN: begin
                if (uturn_finished)  state_nx = ST_TRACK;
                else if (wd_hit)     state_nx = ST_FAIL;
            end
            ST_BUZZ: begin
                if (buzz_finished)   state_nx = ST_DONE;
                else if (wd_hit)     state_nx = ST_FAIL;
            end
            ST_DONE, ST_FAIL: begin
                state_nx = state;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if ((state_nx != state) || !((state == ST_UTURN) || (state == ST_BUZZ))) begin
            wd_nx = '0;
        end else begin
            wd_nx = wd + {{(WD_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Outputs are decoded from the next state so they change with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            color_q     <= COL_NONE;
            laps        <= '0;
            station_cnt <= '0;
            wd          <= '0;
            en_tracking <= 1'b0;
            en_uturn    <= 1'b0;
            en_buzz     <= 1'b0;
            ssd_code    <= '0;
        end else begin
            state       <= state_nx;
            color_q     <= color_nx;
            laps        <= laps_nx;
            station_cnt <= station_nx;
            wd          <= wd_nx;
            en_tracking <= (state_nx == ST_TRACK);
            en_uturn    <= (state_nx == ST_UTURN);
            en_buzz     <= (state_nx == ST_BUZZ);
            ssd_code    <= state_nx;
        end
    end

endmodule

// File: tb/tb_mission_sequencer.sv
// Directed bench for mission_sequencer with short debounce/lap/timeout settings.
module tb_mission_sequencer;

    logic       clk;
    logic       rst;
    logic       hall;
    logic [1:0] object_color;
    logic [1:0] station_color;
    logic       end_of_track;
    logic       uturn_finished;
    logic       buzz_finished;
    logic       en_tracking;
    logic       en_uturn;
    logic       en_buzz;
    logic [3:0] ssd_code;
    logic [3:0] station_cnt;

    int unsigned n_assert;
    int unsigned n_fail;

    mission_sequencer #(
        .DEB_CYCLES    (4),
        .MAX_LAPS      (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hall          (hall),
        .object_color  (object_color),
        .station_color (station_color),
        .end_of_track  (end_of_track),
        .uturn_finished(uturn_finished),
        .buzz_finished (buzz_finished),
        .en_tracking   (en_tracking),
        .en_uturn      (en_uturn),
        .en_buzz       (en_buzz),
        .ssd_code      (ssd_code),
        .station_cnt   (station_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ssd code plus {en_tracking, en_uturn, en_buzz}
    task automatic check_st(input string tag, input logic [3:0] ssd, input logic [2:0] en);
        check({tag, ".ssd"}, {4'h0, ssd_code}, {4'h0, ssd});
        check({tag, ".en"}, {5'h0, en_tracking, en_uturn, en_buzz}, {5'h0, en});
    endtask

    task automatic do_reset();
        hall = 0; object_color = 2'b00; station_color = 2'b00;
        end_of_track = 0; uturn_finished = 0; buzz_finished = 0;
        rst = 0;
        step(2);
        rst = 1;
        step(1);
    endtask

    // From TRACK: hall high for 5 cycles, returns right after CHECK is entered.
    task automatic hall_to_check();
        hall = 1;
        step(5);
        hall = 0;
        step(2);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 0;
        hall = 0; object_color = 2'b00; station_color = 2'b00;
        end_of_track = 0; uturn_finished = 0; buzz_finished = 0;
        step(3);
        check_st("reset", 4'h0, 3'b000);
        check("reset.cnt", {4'h0, station_cnt}, 8'h00);
        rst = 1;
        step(3);
        check_st("idle_hold", 4'h0, 3'b000);

        // Happy path
        object_color = 2'b01; station_color = 2'b01;
        step(1);
        check_st("happy.track", 4'h1, 3'b100);
        object_color = 2'b00;
        hall = 1;
        step(6);
        check_st("happy.pre_check", 4'h1, 3'b100);
        step(1);
        check_st("happy.check", 4'h2, 3'b000);
        step(1);
        check_st("happy.buzz", 4'h4, 3'b001);
        step(2);
        hall = 0;
        uturn_finished = 1;
        step(1);
        uturn_finished = 0;
        check_st("happy.stray_pulse", 4'h4, 3'b001);
        buzz_finished = 1;
        step(1);
        buzz_finished = 0;
        check_st("happy.done", 4'h5, 3'b000);
        step(3);
        check_st("happy.done_hold", 4'h5, 3'b000);

        // Mismatch then match
        do_reset();
        object_color = 2'b10; station_color = 2'b11;
        step(1);
        check_st("mism.track", 4'h1, 3'b100);
        hall_to_check();
        check_st("mism.check", 4'h2, 3'b000);
        step(1);
        check_st("mism.back", 4'h1, 3'b100);
        check("mism.cnt", {4'h0, station_cnt}, 8'h01);
        step(6);
        station_color = 2'b10;
        hall_to_check();
        check_st("mism.check2", 4'h2, 3'b000);
        step(1);
        check_st("mism.buzz", 4'h4, 3'b001);
        check("mism.cnt2", {4'h0, station_cnt}, 8'h01);

        // Glitch reject
        do_reset();
        object_color = 2'b01; station_color = 2'b11;
        step(1);
        hall = 1;
        step(2);
        hall = 0;
        step(8);
        check_st("glitch.track", 4'h1, 3'b100);
        check("glitch.cnt0", {4'h0, station_cnt}, 8'h00);
        hall = 1;
        step(5);
        hall = 0;
        step(1);
        check_st("glitch.edge6", 4'h1, 3'b100);
        step(1);
        check_st("glitch.edge7", 4'h2, 3'b000);
        step(10);
        check("glitch.once", {4'h0, station_cnt}, 8'h01);

        // Laps
        do_reset();
        object_color = 2'b01;
        step(1);
        buzz_finished = 1;
        step(1);
        buzz_finished = 0;
        check_st("laps.stray", 4'h1, 3'b100);
        for (int i = 0; i < 2; i++) begin
            end_of_track = 1;
            step(1);
            end_of_track = 0;
            check_st("laps.uturn", 4'h3, 3'b010);
            step(2);
            uturn_finished = 1;
            step(1);
            uturn_finished = 0;
            check_st("laps.track", 4'h1, 3'b100);
        end
        end_of_track = 1;
        step(1);
        end_of_track = 0;
        check_st("laps.fail", 4'hF, 3'b000);
        step(3);
        check_st("laps.fail_hold", 4'hF, 3'b000);

        // Timeout in BUZZ
        do_reset();
        object_color = 2'b01; station_color = 2'b01;
        step(1);
        hall_to_check();
        step(1);
        check_st("tmo.buzz", 4'h4, 3'b001);
        step(99);
        check_st("tmo.last", 4'h4, 3'b001);
        step(1);
        check_st("tmo.fail", 4'hF, 3'b000);

        // Finished on the timeout cycle
        do_reset();
        object_color = 2'b01; station_color = 2'b01;
        step(1);
        hall_to_check();
        step(1);
        step(99);
        check_st("tmo99.last", 4'h4, 3'b001);
        buzz_finished = 1;
        step(1);
        buzz_finished = 0;
        check_st("tmo99.done", 4'h5, 3'b000);

        // Asynchronous reset mid-UTURN
        do_reset();
        object_color = 2'b01;
        step(1);
        end_of_track = 1;
        step(1);
        end_of_track = 0;
        object_color = 2'b00;
        check_st("areset.uturn", 4'h3, 3'b010);
        #3;
        rst = 0;
        #1;
        check_st("areset.async", 4'h0, 3'b000);
        step(2);
        rst = 1;
        step(1);
        check_st("areset.idle", 4'h0, 3'b000);
        check("areset.cnt", {4'h0, station_cnt}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
